// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
// Bundles the three CPU-stage request channels and the single-port RAM
// command/data signals that meet at ram_port_arbiter.
//   slave  : the arbiter side (takes stage requests and ram_data_out,
//            drives readies, read data, the RAM command, busy and grant)
//   master : the environment side (CPU stages plus the RAM itself)
// Signals:
//   stage12_read / _address / _ready / _data_out   fetch read channel
//   stage3_read  / _address / _ready / _data_out   load read channel
//   stage5_save  / _address / _data_in / _ready    store channel
//   ram_write_enable, ram_address, ram_data_in     command to RAM
//   ram_data_out                                   read data from RAM
//   arb_busy, arb_grant                            arbiter status
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              stage12_read;
  logic [ADDR_W-1:0] stage12_read_address;
  logic              stage12_read_ready;
  logic [DATA_W-1:0] stage12_read_data_out;

  logic              stage3_read;
  logic [ADDR_W-1:0] stage3_read_address;
  logic              stage3_read_ready;
  logic [DATA_W-1:0] stage3_read_data_out;

  logic              stage5_save;
  logic [ADDR_W-1:0] stage5_save_address;
  logic [DATA_W-1:0] stage5_save_data_in;
  logic              stage5_save_ready;

  logic              ram_write_enable;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  logic              arb_busy;
  logic [2:0]        arb_grant;

  modport slave (
    input  stage12_read, stage12_read_address,
    output stage12_read_ready, stage12_read_data_out,
    input  stage3_read, stage3_read_address,
    output stage3_read_ready, stage3_read_data_out,
    input  stage5_save, stage5_save_address, stage5_save_data_in,
    output stage5_save_ready,
    output ram_write_enable, ram_address, ram_data_in,
    input  ram_data_out,
    output arb_busy, arb_grant
  );

  modport master (
    output stage12_read, stage12_read_address,
    input  stage12_read_ready, stage12_read_data_out,
    output stage3_read, stage3_read_address,
    input  stage3_read_ready, stage3_read_data_out,
    output stage5_save, stage5_save_address, stage5_save_data_in,
    input  stage5_save_ready,
    input  ram_write_enable, ram_address, ram_data_in,
    output ram_data_out,
    input  arb_busy, arb_grant
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port synchronous RAM between the fetch (stage12 read),
// load (stage3 read) and store (stage5 save) stages. One request is latched
// per transaction and walked through IDLE -> CMD -> WAIT -> DONE; read data
// and a one-cycle ready go back to the winner.
//
// Ports:
//   ram_clk  in   sole clock, everything on posedge
//   rst      in   synchronous active-low reset
//   bus      ram_port_arbiter_if.slave (stage channels, RAM port, status)
//
// Build option:
//   RAM_ARB_ROUND_ROBIN_EN  undefined: fixed priority stage5 > stage3 > stage12
//                           defined:   rotating priority, granted requester
//                                      drops to lowest (5 -> 3 -> 12 -> 5)
//
// Grant encoding is one-hot {stage5, stage3, stage12}.
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              ram_clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_S12  = 3'b001;
  localparam logic [2:0] GNT_S3   = 3'b010;
  localparam logic [2:0] GNT_S5   = 3'b100;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [2:0]        w_req;
  logic [2:0]        w_first;
  logic [2:0]        w_win;
  logic [ADDR_W-1:0] w_win_addr;

  logic [2:0]        r_grant;
  logic              r_busy;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_s12_rdy;
  logic              r_s3_rdy;
  logic              r_s5_rdy;
  logic [DATA_W-1:0] r_s12_dout;
  logic [DATA_W-1:0] r_s3_dout;

  // Walk the cyclic order 5 -> 3 -> 12 starting at 'first'; return the
  // first requester found (one-hot), or zero when nobody asks.
  function automatic logic [2:0] pick_first(input logic [2:0] req,
                                            input logic [2:0] first);
    logic [2:0] v_pos;
    logic [2:0] v_win;
    v_win = GNT_NONE;
    v_pos = first;
    for (int k = 0; k < 3; k++) begin
      if ((v_win == GNT_NONE) && ((req & v_pos) != GNT_NONE)) begin
        v_win = v_pos;
      end else begin
        v_win = v_win;
      end
      v_pos = {v_pos[0], v_pos[2:1]};
    end
    return v_win;
  endfunction

  assign w_req = {bus.stage5_save, bus.stage3_read, bus.stage12_read};

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Highest-priority requester for the next arbitration (one-hot).
  logic [2:0] r_rr_ptr;

  // Rotating pointer: after a grant the winner becomes lowest priority.
  always_ff @(posedge ram_clk) begin
    if (!rst) begin
      r_rr_ptr <= GNT_S5;
    end else if ((r_state == ST_IDLE) && (w_win != GNT_NONE)) begin
      r_rr_ptr <= {w_win[0], w_win[2:1]};
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // A corrupted (non one-hot) pointer falls back to the reset ordering.
  always_comb begin
    w_first = GNT_S5;
    case (r_rr_ptr)
      GNT_S5:  w_first = GNT_S5;
      GNT_S3:  w_first = GNT_S3;
      GNT_S12: w_first = GNT_S12;
      default: w_first = GNT_S5;
    endcase
  end
`else
  // Fixed priority always starts the search at the store port.
  always_comb begin
    w_first = GNT_S5;
  end
`endif

  // Winner selection from the live request lines.
  always_comb begin
    w_win = pick_first(w_req, w_first);
  end

  // Address of the winner, latched into the RAM address register in IDLE.
  always_comb begin
    w_win_addr = {ADDR_W{1'b0}};
    case (w_win)
      GNT_S5:  w_win_addr = bus.stage5_save_address;
      GNT_S3:  w_win_addr = bus.stage3_read_address;
      GNT_S12: w_win_addr = bus.stage12_read_address;
      default: w_win_addr = {ADDR_W{1'b0}};
    endcase
  end

  // FSM state register.
  always_ff @(posedge ram_clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: fixed four-cycle walk once a request is accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req != 3'b000) begin
          w_state_nxt = ST_CMD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CMD:  w_state_nxt = ST_WAIT;
      ST_WAIT: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered datapath: RAM command, grant/busy, read data and readies.
  // The RAM address/data registers double as the transaction latches, so
  // operand changes after the grant never reach the RAM.
  always_ff @(posedge ram_clk) begin
    if (!rst) begin
      r_grant    <= GNT_NONE;
      r_busy     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= {ADDR_W{1'b0}};
      r_din      <= {DATA_W{1'b0}};
      r_s12_rdy  <= 1'b0;
      r_s3_rdy   <= 1'b0;
      r_s5_rdy   <= 1'b0;
      r_s12_dout <= {DATA_W{1'b0}};
      r_s3_dout  <= {DATA_W{1'b0}};
    end else begin
      r_s12_rdy <= 1'b0;
      r_s3_rdy  <= 1'b0;
      r_s5_rdy  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win != GNT_NONE) begin
            r_grant <= w_win;
            r_busy  <= 1'b1;
            r_addr  <= w_win_addr;
            if (w_win == GNT_S5) begin
              r_we  <= 1'b1;
              r_din <= bus.stage5_save_data_in;
            end else begin
              r_we  <= 1'b0;
            end
          end else begin
            r_we <= 1'b0;
          end
        end
        ST_CMD: begin
          r_we <= r_we;
        end
        ST_WAIT: begin
          // RAM took the command on the edge entering WAIT.
          r_we <= 1'b0;
        end
        ST_DONE: begin
          // ram_data_out still reflects the latched address here because
          // the address register is held through the whole transaction.
          r_grant <= GNT_NONE;
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
          case (r_grant)
            GNT_S5:  r_s5_rdy <= 1'b1;
            GNT_S3: begin
              r_s3_rdy  <= 1'b1;
              r_s3_dout <= bus.ram_data_out;
            end
            GNT_S12: begin
              r_s12_rdy  <= 1'b1;
              r_s12_dout <= bus.ram_data_out;
            end
            default: r_s5_rdy <= 1'b0;
          endcase
        end
        default: begin
          r_grant <= GNT_NONE;
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stage12_read_ready    = r_s12_rdy;
  assign bus.stage12_read_data_out = r_s12_dout;
  assign bus.stage3_read_ready     = r_s3_rdy;
  assign bus.stage3_read_data_out  = r_s3_dout;
  assign bus.stage5_save_ready     = r_s5_rdy;
  assign bus.ram_write_enable      = r_we;
  assign bus.ram_address           = r_addr;
  assign bus.ram_data_in           = r_din;
  assign bus.arb_busy              = r_busy;
  assign bus.arb_grant             = r_grant;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter with a transaction-level reference
// model (age counter per transaction, priority list, byte-array memory) that
// is compared against every DUT output on each falling edge, plus literal
// expectations for latency, data and grant order.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ram_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Physical single-port synchronous RAM (read-before-write).
  logic [7:0] ram_mem [0:65535];
  always @(posedge clk) begin
    if (bus.ram_write_enable) ram_mem[bus.ram_address] <= bus.ram_data_in;
    bus.ram_data_out <= ram_mem[bus.ram_address];
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_mem [0:65535];
  bit          m_active = 1'b0;
  bit          m_was;
  int          m_age = 0;
  int          m_who = 0;
  int          m_ptr = 0;
  int          m_idx;
  logic [15:0] m_taddr;
  logic [7:0]  m_tdata;
  logic        m_s12_rdy = 1'b0, m_s3_rdy = 1'b0, m_s5_rdy = 1'b0;
  logic [7:0]  m_s12_dout = 8'h00, m_s3_dout = 8'h00;
  logic        m_we = 1'b0, m_busy = 1'b0;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0]  m_din = 8'h00;
  logic [2:0]  m_grant = 3'b000;

  // Priority list index: 0 = stage5, 1 = stage3, 2 = stage12.
  function automatic bit req_of(input int i);
    case (i)
      0: return bus.stage5_save;
      1: return bus.stage3_read;
      default: return bus.stage12_read;
    endcase
  endfunction

  always @(posedge clk) begin
    // RAM latches the store on the edge after the grant, even if reset hits then.
    if (m_active && m_age == 1 && m_who == 5) m_mem[m_taddr] = m_tdata;
    m_s12_rdy = 1'b0; m_s3_rdy = 1'b0; m_s5_rdy = 1'b0;
    if (!rst) begin
      m_active = 1'b0; m_age = 0; m_ptr = 0;
      m_we = 1'b0; m_busy = 1'b0; m_grant = 3'b000;
      m_addr = 16'h0000; m_din = 8'h00;
      m_s12_dout = 8'h00; m_s3_dout = 8'h00;
    end else begin
      m_was = m_active;
      if (m_active) begin
        m_age++;
        if (m_age == 3) m_we = 1'b0;
        if (m_age == 4) begin
          case (m_who)
            5:  m_s5_rdy = 1'b1;
            3:  begin m_s3_rdy = 1'b1;  m_s3_dout  = m_mem[m_taddr]; end
            default: begin m_s12_rdy = 1'b1; m_s12_dout = m_mem[m_taddr]; end
          endcase
          m_active = 1'b0; m_busy = 1'b0; m_grant = 3'b000;
        end
      end
      if (!m_was) begin
        m_idx = -1;
        for (int k = 0; k < 3; k++)
          if (m_idx < 0 && req_of((m_ptr + k) % 3)) m_idx = (m_ptr + k) % 3;
        if (m_idx >= 0) begin
          m_active = 1'b1; m_age = 1; m_busy = 1'b1;
          case (m_idx)
            0: begin
              m_who = 5; m_grant = 3'b100;
              m_taddr = bus.stage5_save_address; m_tdata = bus.stage5_save_data_in;
              m_din = m_tdata; m_we = 1'b1;
            end
            1: begin m_who = 3;  m_grant = 3'b010; m_taddr = bus.stage3_read_address; end
            default: begin m_who = 12; m_grant = 3'b001; m_taddr = bus.stage12_read_address; end
          endcase
          m_addr = m_taddr;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          m_ptr = (m_idx + 1) % 3;
`endif
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("s12_ready", bus.stage12_read_ready, m_s12_rdy);
    chk("s3_ready",  bus.stage3_read_ready,  m_s3_rdy);
    chk("s5_ready",  bus.stage5_save_ready,  m_s5_rdy);
    chk("s12_data",  bus.stage12_read_data_out, m_s12_dout);
    chk("s3_data",   bus.stage3_read_data_out,  m_s3_dout);
    chk("ram_we",    bus.ram_write_enable, m_we);
    chk("ram_addr",  bus.ram_address, m_addr);
    chk("ram_din",   bus.ram_data_in, m_din);
    chk("busy",      bus.arb_busy, m_busy);
    chk("grant",     bus.arb_grant, m_grant);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until every raised request has seen its ready; record cycle of each.
  task automatic serve(input int max, output int t5, output int t3, output int t12);
    t5 = 0; t3 = 0; t12 = 0;
    for (int t = 1; t <= max; t++) begin
      tick();
      if (bus.stage5_save_ready)  begin t5  = t; bus.stage5_save  = 1'b0; end
      if (bus.stage3_read_ready)  begin t3  = t; bus.stage3_read  = 1'b0; end
      if (bus.stage12_read_ready) begin t12 = t; bus.stage12_read = 1'b0; end
      if (!bus.stage5_save && !bus.stage3_read && !bus.stage12_read) break;
    end
    chk("serve_timeout", {29'd0, bus.stage5_save, bus.stage3_read, bus.stage12_read}, 32'd0);
    bus.stage5_save = 1'b0; bus.stage3_read = 1'b0; bus.stage12_read = 1'b0;
  endtask

  int t5, t3, t12;
  int alt_who [4];
  int alt_exp [4];
  int got;

  initial begin
    bus.stage12_read = 1'b0; bus.stage12_read_address = 16'h0000;
    bus.stage3_read  = 1'b0; bus.stage3_read_address  = 16'h0000;
    bus.stage5_save  = 1'b0; bus.stage5_save_address  = 16'h0000;
    bus.stage5_save_data_in = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = i[15:0];
      ram_mem[i] = a[7:0] ^ a[15:8];
      m_mem[i]   = a[7:0] ^ a[15:8];
    end
    ram_mem[16'h0010] = 8'h01; m_mem[16'h0010] = 8'h01;
    ram_mem[16'h0020] = 8'h5C; m_mem[16'h0020] = 8'h5C;
    ram_mem[16'h0030] = 8'h3C; m_mem[16'h0030] = 8'h3C;

    // Reset held 3 cycles with every request raised.
    rst = 1'b0;
    bus.stage12_read = 1'b1; bus.stage12_read_address = 16'h0010;
    bus.stage3_read  = 1'b1; bus.stage3_read_address  = 16'h0020;
    bus.stage5_save  = 1'b1; bus.stage5_save_address  = 16'h0400;
    bus.stage5_save_data_in = 8'hEE;
    repeat (3) tick();
    chk("rst_busy",  bus.arb_busy, 1'b0);
    chk("rst_grant", bus.arb_grant, 3'b000);
    chk("rst_we",    bus.ram_write_enable, 1'b0);
    chk("rst_s12d",  bus.stage12_read_data_out, 8'h00);
    chk("rst_nowrite", ram_mem[16'h0400], 8'h04);
    bus.stage12_read = 1'b0; bus.stage3_read = 1'b0; bus.stage5_save = 1'b0;
    rst = 1'b1;
    tick();

    // Single fetch.
    bus.stage12_read_address = 16'h0010; bus.stage12_read = 1'b1;
    serve(10, t5, t3, t12);
    chk("fetch_latency", t12, 4);
    chk("fetch_data", bus.stage12_read_data_out, 8'h01);
    tick();
    chk("fetch_pulse", bus.stage12_read_ready, 1'b0);

    // Store then load of the same address.
    bus.stage5_save_address = 16'h0100; bus.stage5_save_data_in = 8'hA5; bus.stage5_save = 1'b1;
    serve(10, t5, t3, t12);
    chk("store_latency", t5, 4);
    bus.stage3_read_address = 16'h0100; bus.stage3_read = 1'b1;
    serve(10, t5, t3, t12);
    chk("load_latency", t3, 4);
    chk("load_data", bus.stage3_read_data_out, 8'hA5);

    // Three-way contention.
    bus.stage5_save_address  = 16'h0200; bus.stage5_save_data_in = 8'h77;
    bus.stage3_read_address  = 16'h0030;
    bus.stage12_read_address = 16'h0020;
    bus.stage5_save = 1'b1; bus.stage3_read = 1'b1; bus.stage12_read = 1'b1;
    serve(20, t5, t3, t12);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    chk("cont_t12", t12, 4); chk("cont_t5", t5, 8); chk("cont_t3", t3, 12);
`else
    chk("cont_t5", t5, 4); chk("cont_t3", t3, 8); chk("cont_t12", t12, 12);
`endif
    chk("cont_s3d",  bus.stage3_read_data_out,  8'h3C);
    chk("cont_s12d", bus.stage12_read_data_out, 8'h5C);

    // Stage5 and stage12 held permanently after a fresh reset.
    rst = 1'b0; tick(); rst = 1'b1;
    bus.stage5_save_address = 16'h0200; bus.stage5_save_data_in = 8'h33;
    bus.stage12_read_address = 16'h0010;
    bus.stage5_save = 1'b1; bus.stage12_read = 1'b1;
    got = 0;
    for (int t = 0; t < 30 && got < 4; t++) begin
      tick();
      if (bus.stage5_save_ready)       begin alt_who[got] = 5;  got++; end
      else if (bus.stage12_read_ready) begin alt_who[got] = 12; got++; end
    end
    bus.stage5_save = 1'b0; bus.stage12_read = 1'b0;
    chk("alt_count", got, 4);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    alt_exp = '{5, 12, 5, 12};
`else
    alt_exp = '{5, 5, 5, 5};
`endif
    for (int i = 0; i < 4; i++)
      if (i < got) chk("alt_order", alt_who[i], alt_exp[i]);
    tick();

    // Reset during the WAIT cycle of a store, with a load pending.
    bus.stage5_save_address = 16'h0300; bus.stage5_save_data_in = 8'h99;
    bus.stage3_read_address = 16'h0030;
    bus.stage5_save = 1'b1; bus.stage3_read = 1'b1;
    tick(); tick();
    chk("mid_busy",  bus.arb_busy, 1'b1);
    chk("mid_grant", bus.arb_grant, 3'b100);
    rst = 1'b0;
    tick();
    chk("mid_no_rdy", bus.stage5_save_ready, 1'b0);
    chk("mid_idle",   bus.arb_busy, 1'b0);
    chk("mid_gnt0",   bus.arb_grant, 3'b000);
    rst = 1'b1;
    serve(20, t5, t3, t12);
    chk("rearb_t5", t5, 4);
    chk("rearb_t3", t3, 8);
    chk("rearb_s3d", bus.stage3_read_data_out, 8'h3C);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
